// File: rtl/commit_probe_pkg.sv
// Shared types for commit_probe: FSM state encoding, the commit record layout
// and counter limits.
package commit_probe_pkg;

  localparam int unsigned CNT_W_DEF = 64;
  localparam int unsigned XLEN_DEF  = 32;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } probe_state_e;

  // Field set consumed by the syncer; sized from the package defaults.
  typedef struct packed {
    logic [XLEN_DEF-1:0]  pc;
    logic [XLEN_DEF-1:0]  npc;
    logic [XLEN_DEF-1:0]  inst;
    logic                 icache_need;
    logic                 icache_hit;
    logic [CNT_W_DEF-1:0] icache_cost;
    logic [CNT_W_DEF-1:0] icache_miss;
    logic [CNT_W_DEF-1:0] idu_cost;
    logic [CNT_W_DEF-1:0] exu_cost;
    logic [CNT_W_DEF-1:0] lsu_cost;
    logic [CNT_W_DEF-1:0] wbu_cost;
    logic                 mem_ren;
    logic                 mem_wen;
    logic [2:0]           mem_size;
    logic [XLEN_DEF-1:0]  mem_addr;
    logic [XLEN_DEF-1:0]  mem_data;
    logic                 skip_difftest;
    logic                 sim_end;
    logic [31:0]          exit_code;
  } commit_rec_t;

endpackage

// File: rtl/commit_probe_if.sv
// Stage handshake observation bus and commit record outputs of commit_probe.
interface commit_probe_if
  import commit_probe_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             ifu_req_fire;
  logic             ifu_resp_fire;
  logic             idu_fire;
  logic             exu_fire;
  logic             lsu_fire;
  logic             wbu_fire;
  logic             ifu_cached;
  logic             icache_refill;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  npc;
  logic [XLEN-1:0]  inst;
  logic             exu_mem;
  logic             mem_ren;
  logic             mem_wen;
  logic [2:0]       mem_size;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_data;
  logic             skip_difftest;
  logic             sim_end;
  logic [31:0]      exit_code;

  logic             commit_en;
  logic [XLEN-1:0]  c_pc;
  logic [XLEN-1:0]  c_npc;
  logic [XLEN-1:0]  c_inst;
  logic             c_icache_need;
  logic             c_icache_hit;
  logic [CNT_W-1:0] c_icache_cost;
  logic [CNT_W-1:0] c_icache_miss;
  logic [CNT_W-1:0] c_idu_cost;
  logic [CNT_W-1:0] c_exu_cost;
  logic [CNT_W-1:0] c_lsu_cost;
  logic [CNT_W-1:0] c_wbu_cost;
  logic             c_mem_ren;
  logic             c_mem_wen;
  logic [2:0]       c_mem_size;
  logic [XLEN-1:0]  c_mem_addr;
  logic [XLEN-1:0]  c_mem_data;
  logic             c_skip_difftest;
  logic             c_sim_end;
  logic [31:0]      c_exit_code;
  logic             proto_err;

  modport master (
    output ifu_req_fire, ifu_resp_fire, idu_fire, exu_fire, lsu_fire, wbu_fire,
           ifu_cached, icache_refill, pc, npc, inst, exu_mem,
           mem_ren, mem_wen, mem_size, mem_addr, mem_data,
           skip_difftest, sim_end, exit_code,
    input  commit_en, c_pc, c_npc, c_inst, c_icache_need, c_icache_hit,
           c_icache_cost, c_icache_miss, c_idu_cost, c_exu_cost, c_lsu_cost, c_wbu_cost,
           c_mem_ren, c_mem_wen, c_mem_size, c_mem_addr, c_mem_data,
           c_skip_difftest, c_sim_end, c_exit_code, proto_err
  );

  modport slave (
    input  ifu_req_fire, ifu_resp_fire, idu_fire, exu_fire, lsu_fire, wbu_fire,
           ifu_cached, icache_refill, pc, npc, inst, exu_mem,
           mem_ren, mem_wen, mem_size, mem_addr, mem_data,
           skip_difftest, sim_end, exit_code,
    output commit_en, c_pc, c_npc, c_inst, c_icache_need, c_icache_hit,
           c_icache_cost, c_icache_miss, c_idu_cost, c_exu_cost, c_lsu_cost, c_wbu_cost,
           c_mem_ren, c_mem_wen, c_mem_size, c_mem_addr, c_mem_data,
           c_skip_difftest, c_sim_end, c_exit_code, proto_err
  );
endinterface

// File: rtl/commit_probe_sat_counter.sv
// Saturating cycle counter; cnt_o already includes the current cycle's
// increment so a same-cycle snapshot sees the final count.
module sat_counter
  import commit_probe_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_o = cnt_q;
    if (inc_i && (cnt_q != W'(CNT_MAX))) cnt_o = cnt_q + W'(1);
    cnt_d = clr_i ? '0 : cnt_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/commit_probe.sv
// Commit-record producer for the multi-cycle core. Define
// COMMIT_PROBE_MEM_TRACE_EN to sample and publish the LSU access fields.
module commit_probe
  import commit_probe_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic          clock,
  input  logic          reset,
  commit_probe_if.slave bus
);
  probe_state_e    state_q;
  commit_rec_t     rec_q, rec_d;
  logic            commit_en_q, proto_err_q, need_q;
  logic [XLEN-1:0] pc_q, inst_q;

  logic req_ok, resp_ok, idu_ok, exu_ok, lsu_ok, wbu_ok, bad_fire;
  logic [CNT_W-1:0] icache_cnt, miss_cnt, idu_cnt, exu_cnt, lsu_cnt, wbu_cnt;

  // A fire counts only in the state that expects it; anything else is flagged and dropped.
  always_comb begin
    req_ok  = bus.ifu_req_fire &&
              ((state_q == S_IDLE) || ((state_q == S_WB) && bus.wbu_fire));
    resp_ok = bus.ifu_resp_fire && (state_q == S_FETCH);
    idu_ok  = bus.idu_fire      && (state_q == S_DECODE);
    exu_ok  = bus.exu_fire      && (state_q == S_EXEC);
    lsu_ok  = bus.lsu_fire      && (state_q == S_MEM);
    wbu_ok  = bus.wbu_fire      && (state_q == S_WB);
    bad_fire = (bus.ifu_req_fire && !req_ok) || (bus.ifu_resp_fire && !resp_ok) ||
               (bus.idu_fire && !idu_ok) || (bus.exu_fire && !exu_ok) ||
               (bus.lsu_fire && !lsu_ok) || (bus.wbu_fire && !wbu_ok);
  end

  sat_counter #(.W(CNT_W)) u_icache_cnt (.clk_i(clock), .rst_ni(reset), .clr_i(req_ok),
    .inc_i(state_q == S_FETCH), .cnt_o(icache_cnt));
  sat_counter #(.W(CNT_W)) u_miss_cnt (.clk_i(clock), .rst_ni(reset), .clr_i(req_ok),
    .inc_i((state_q == S_FETCH) && bus.icache_refill), .cnt_o(miss_cnt));
  sat_counter #(.W(CNT_W)) u_idu_cnt (.clk_i(clock), .rst_ni(reset), .clr_i(req_ok),
    .inc_i(state_q == S_DECODE), .cnt_o(idu_cnt));
  sat_counter #(.W(CNT_W)) u_exu_cnt (.clk_i(clock), .rst_ni(reset), .clr_i(req_ok),
    .inc_i(state_q == S_EXEC), .cnt_o(exu_cnt));
  sat_counter #(.W(CNT_W)) u_lsu_cnt (.clk_i(clock), .rst_ni(reset), .clr_i(req_ok),
    .inc_i(state_q == S_MEM), .cnt_o(lsu_cnt));
  sat_counter #(.W(CNT_W)) u_wbu_cnt (.clk_i(clock), .rst_ni(reset), .clr_i(req_ok),
    .inc_i(state_q == S_WB), .cnt_o(wbu_cnt));

`ifdef COMMIT_PROBE_MEM_TRACE_EN
  logic            mem_ren_q, mem_wen_q;
  logic [2:0]      mem_size_q;
  logic [XLEN-1:0] mem_addr_q, mem_data_q;

  // Cleared at fetch so an instruction that skips MEM commits an empty access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
      mem_size_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else if (lsu_ok) begin
      mem_ren_q  <= bus.mem_ren;
      mem_wen_q  <= bus.mem_wen;
      mem_size_q <= bus.mem_size;
      mem_addr_q <= bus.mem_addr;
      mem_data_q <= bus.mem_data;
    end else if (req_ok) begin
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
      mem_size_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end
  end
`else
  logic unused_mem;
  assign unused_mem = ^{bus.mem_ren, bus.mem_wen, bus.mem_size, bus.mem_addr, bus.mem_data};
`endif

  always_comb begin
    rec_d               = '0;
    rec_d.pc            = pc_q;
    rec_d.npc           = bus.npc;
    rec_d.inst          = inst_q;
    rec_d.icache_need   = need_q;
    rec_d.icache_hit    = (miss_cnt == '0);
    rec_d.icache_cost   = icache_cnt;
    rec_d.icache_miss   = miss_cnt;
    rec_d.idu_cost      = idu_cnt;
    rec_d.exu_cost      = exu_cnt;
    rec_d.lsu_cost      = lsu_cnt;
    rec_d.wbu_cost      = wbu_cnt;
`ifdef COMMIT_PROBE_MEM_TRACE_EN
    rec_d.mem_ren       = mem_ren_q;
    rec_d.mem_wen       = mem_wen_q;
    rec_d.mem_size      = mem_size_q;
    rec_d.mem_addr      = mem_addr_q;
    rec_d.mem_data      = mem_data_q;
`endif
    rec_d.skip_difftest = bus.skip_difftest;
    rec_d.sim_end       = bus.sim_end;
    rec_d.exit_code     = bus.exit_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rec_q       <= '0;
      commit_en_q <= 1'b0;
      proto_err_q <= 1'b0;
      need_q      <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
    end else begin
      commit_en_q <= wbu_ok;
      if (bad_fire) proto_err_q <= 1'b1;
      if (req_ok)   need_q <= bus.ifu_cached;
      if (resp_ok) begin
        pc_q   <= bus.pc;
        inst_q <= bus.inst;
      end
      if (wbu_ok) rec_q <= rec_d;
      case (state_q)
        S_IDLE:   if (req_ok)  state_q <= S_FETCH;
        S_FETCH:  if (resp_ok) state_q <= S_DECODE;
        S_DECODE: if (idu_ok)  state_q <= S_EXEC;
        S_EXEC:   if (exu_ok)  state_q <= bus.exu_mem ? S_MEM : S_WB;
        S_MEM:    if (lsu_ok)  state_q <= S_WB;
        S_WB:     if (wbu_ok)  state_q <= req_ok ? S_FETCH : S_IDLE;
        default:               state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.commit_en       = commit_en_q;
  assign bus.c_pc            = rec_q.pc;
  assign bus.c_npc           = rec_q.npc;
  assign bus.c_inst          = rec_q.inst;
  assign bus.c_icache_need   = rec_q.icache_need;
  assign bus.c_icache_hit    = rec_q.icache_hit;
  assign bus.c_icache_cost   = rec_q.icache_cost;
  assign bus.c_icache_miss   = rec_q.icache_miss;
  assign bus.c_idu_cost      = rec_q.idu_cost;
  assign bus.c_exu_cost      = rec_q.exu_cost;
  assign bus.c_lsu_cost      = rec_q.lsu_cost;
  assign bus.c_wbu_cost      = rec_q.wbu_cost;
  assign bus.c_mem_ren       = rec_q.mem_ren;
  assign bus.c_mem_wen       = rec_q.mem_wen;
  assign bus.c_mem_size      = rec_q.mem_size;
  assign bus.c_mem_addr      = rec_q.mem_addr;
  assign bus.c_mem_data      = rec_q.mem_data;
  assign bus.c_skip_difftest = rec_q.skip_difftest;
  assign bus.c_sim_end       = rec_q.sim_end;
  assign bus.c_exit_code     = rec_q.exit_code;
  assign bus.proto_err       = proto_err_q;
endmodule

// File: tb/tb_commit_probe.sv
// Randomized bench for commit_probe: instructions are described by stage
// lengths and the expected record is derived from those lengths and fire-time inputs.
module tb_commit_probe;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  commit_probe_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  commit_probe #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc, npc, inst, addr, data, exit_code;
    logic        need, ren, wen, skip, send;
    logic [2:0]  size;
    int          f, miss, d, e, l, w;
  } exp_t;

  bit   exp_err = 1'b0;
  logic next_need = 1'b0;
  int   mem_kind = 0;
  bit   force_end = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_fires();
    bus.ifu_req_fire  = 1'b0;
    bus.ifu_resp_fire = 1'b0;
    bus.idu_fire      = 1'b0;
    bus.exu_fire      = 1'b0;
    bus.lsu_fire      = 1'b0;
    bus.wbu_fire      = 1'b0;
  endtask

  task automatic rand_data();
    bus.pc            = $urandom;
    bus.npc           = $urandom;
    bus.inst          = $urandom;
    bus.ifu_cached    = 1'($urandom);
    bus.icache_refill = 1'($urandom);
    bus.exu_mem       = 1'($urandom);
    bus.mem_ren       = 1'($urandom);
    bus.mem_wen       = 1'($urandom);
    bus.mem_size      = 3'($urandom);
    bus.mem_addr      = $urandom;
    bus.mem_data      = $urandom;
    bus.skip_difftest = 1'($urandom);
    bus.sim_end       = 1'($urandom);
    bus.exit_code     = $urandom;
  endtask

  // One instruction: nf FETCH, nd DECODE, ne EXEC, nm MEM (0 = none), nw WB cycles.
  task automatic run_instr(input int nf, input int nd, input int ne, input int nm, input int nw,
                           input bit chain_in, input bit chain_out, input int miss_first,
                           input bit stray);
    exp_t ex;
    ex = '{default: 0};
    ex.f = nf; ex.d = nd; ex.e = ne; ex.l = nm; ex.w = nw;
    if (!chain_in) begin
      rand_data(); clear_fires();
      bus.ifu_req_fire = 1'b1;
      ex.need = bus.ifu_cached;
      tick();
    end else begin
      ex.need = next_need;
    end
    for (int i = 0; i < nf; i++) begin
      rand_data(); clear_fires();
      if (miss_first >= 0) bus.icache_refill = (i < miss_first);
      if (bus.icache_refill) ex.miss++;
      if (stray && i == 0 && nf > 1) begin
        bus.idu_fire = 1'b1;
        exp_err = 1'b1;
      end
      if (i == nf - 1) begin
        bus.ifu_resp_fire = 1'b1;
        ex.pc = bus.pc;
        ex.inst = bus.inst;
      end
      tick();
    end
    for (int i = 0; i < nd; i++) begin
      rand_data(); clear_fires();
      bus.idu_fire = (i == nd - 1);
      tick();
    end
    for (int i = 0; i < ne; i++) begin
      rand_data(); clear_fires();
      if (i == ne - 1) begin
        bus.exu_fire = 1'b1;
        bus.exu_mem  = (nm != 0);
      end
      tick();
    end
    for (int i = 0; i < nm; i++) begin
      rand_data(); clear_fires();
      if (i == nm - 1) begin
        bus.lsu_fire = 1'b1;
        if (mem_kind == 1) begin
          bus.mem_ren = 1'b1; bus.mem_wen = 1'b0; bus.mem_size = 3'd2; bus.mem_addr = 32'h8000_0010;
        end else if (mem_kind == 2) begin
          bus.mem_ren = 1'b0; bus.mem_wen = 1'b1; bus.mem_size = 3'd2;
        end
        ex.ren = bus.mem_ren; ex.wen = bus.mem_wen; ex.size = bus.mem_size;
        ex.addr = bus.mem_addr; ex.data = bus.mem_data;
      end
      tick();
    end
    for (int i = 0; i < nw; i++) begin
      rand_data(); clear_fires();
      if (i == nw - 1) begin
        bus.wbu_fire = 1'b1;
        if (force_end) begin
          bus.sim_end = 1'b1;
          bus.exit_code = 32'd0;
        end
        ex.npc = bus.npc; ex.skip = bus.skip_difftest; ex.send = bus.sim_end;
        ex.exit_code = bus.exit_code;
        if (chain_out) begin
          bus.ifu_req_fire = 1'b1;
          next_need = bus.ifu_cached;
        end
        check("commit_early", 64'(bus.commit_en), 64'(0));
      end
      tick();
    end
`ifndef COMMIT_PROBE_MEM_TRACE_EN
    ex.ren = 1'b0; ex.wen = 1'b0; ex.size = '0; ex.addr = '0; ex.data = '0;
`endif
    check("commit_en",   64'(bus.commit_en), 64'(1));
    check("c_pc",        64'(bus.c_pc), 64'(ex.pc));
    check("c_npc",       64'(bus.c_npc), 64'(ex.npc));
    check("c_inst",      64'(bus.c_inst), 64'(ex.inst));
    check("icache_need", 64'(bus.c_icache_need), 64'(ex.need));
    check("icache_hit",  64'(bus.c_icache_hit), 64'(ex.miss == 0));
    check("icache_cost", bus.c_icache_cost, 64'(ex.f));
    check("icache_miss", bus.c_icache_miss, 64'(ex.miss));
    check("idu_cost",    bus.c_idu_cost, 64'(ex.d));
    check("exu_cost",    bus.c_exu_cost, 64'(ex.e));
    check("lsu_cost",    bus.c_lsu_cost, 64'(ex.l));
    check("wbu_cost",    bus.c_wbu_cost, 64'(ex.w));
    check("mem_ren",     64'(bus.c_mem_ren), 64'(ex.ren));
    check("mem_wen",     64'(bus.c_mem_wen), 64'(ex.wen));
    check("mem_size",    64'(bus.c_mem_size), 64'(ex.size));
    check("mem_addr",    64'(bus.c_mem_addr), 64'(ex.addr));
    check("mem_data",    64'(bus.c_mem_data), 64'(ex.data));
    check("skip",        64'(bus.c_skip_difftest), 64'(ex.skip));
    check("sim_end",     64'(bus.c_sim_end), 64'(ex.send));
    check("exit_code",   64'(bus.c_exit_code), 64'(ex.exit_code));
    check("proto_err",   64'(bus.proto_err), 64'(exp_err));
    if (!chain_out) begin
      rand_data(); clear_fires();
      tick();
      check("commit_width", 64'(bus.commit_en), 64'(0));
      check("hold_pc",      64'(bus.c_pc), 64'(ex.pc));
    end
  endtask

  initial begin
    int nf, nd, ne, nm, nw;
    bit co, prev_chain;
    clear_fires(); rand_data();
    tick(); tick();
    check("rst_commit_en", 64'(bus.commit_en), 64'(0));
    check("rst_proto_err", 64'(bus.proto_err), 64'(0));
    check("rst_c_pc",      64'(bus.c_pc), 64'(0));
    check("rst_icache",    bus.c_icache_cost, 64'(0));
    reset = 1'b1;
    tick();

    run_instr(3, 1, 2, 0, 1, 1'b0, 1'b0, -1, 1'b0);
    mem_kind = 1;
    run_instr(12, 1, 1, 4, 1, 1'b0, 1'b0, 10, 1'b0);
    mem_kind = 0;
    run_instr(2, 1, 1, 0, 1, 1'b0, 1'b1, -1, 1'b0);
    run_instr(3, 2, 1, 1, 2, 1'b1, 1'b0, -1, 1'b0);
    force_end = 1'b1; mem_kind = 2;
    run_instr(2, 1, 1, 2, 1, 1'b0, 1'b0, -1, 1'b0);
    force_end = 1'b0; mem_kind = 0;

    prev_chain = 1'b0;
    for (int k = 0; k < 30; k++) begin
      co = (k != 29) && ($urandom_range(0, 2) == 0);
      nf = int'($urandom_range(1, 6));
      nd = int'($urandom_range(1, 3));
      ne = int'($urandom_range(1, 3));
      nm = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      nw = int'($urandom_range(1, 3));
      if (!prev_chain) begin
        repeat ($urandom_range(0, 2)) begin
          rand_data(); clear_fires(); tick();
        end
      end
      run_instr(nf, nd, ne, nm, nw, prev_chain, co, -1, 1'b0);
      prev_chain = co;
    end

    run_instr(3, 1, 1, 0, 1, 1'b0, 1'b0, -1, 1'b1);
    run_instr(2, 1, 1, 1, 1, 1'b0, 1'b0, -1, 1'b0);

    // Reset during EXEC discards the partial instruction.
    rand_data(); clear_fires(); bus.ifu_req_fire = 1'b1; tick();
    rand_data(); clear_fires(); bus.ifu_resp_fire = 1'b1; tick();
    rand_data(); clear_fires(); bus.idu_fire = 1'b1; tick();
    rand_data(); clear_fires(); tick();
    reset = 1'b0;
    #1;
    check("mid_rst_commit_en", 64'(bus.commit_en), 64'(0));
    check("mid_rst_proto_err", 64'(bus.proto_err), 64'(0));
    check("mid_rst_c_pc",      64'(bus.c_pc), 64'(0));
    check("mid_rst_icache",    bus.c_icache_cost, 64'(0));
    check("mid_rst_wbu",       bus.c_wbu_cost, 64'(0));
    check("mid_rst_exit",      64'(bus.c_exit_code), 64'(0));
    tick(); tick();
    reset = 1'b1;
    exp_err = 1'b0;
    repeat (3) begin
      rand_data(); clear_fires(); tick();
      check("post_rst_idle", 64'(bus.commit_en), 64'(0));
    end
    run_instr(4, 1, 3, 2, 1, 1'b0, 1'b0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
